round_key_memory: RTL

ROUND_KEY_MEMORY -- requirements
Module: round_key_memory

---
 rtl/round_key_memory.sv | 134 +++++++++++++
 1 files changed

// File: rtl/round_key_memory.sv
// Stores an expanded AES key schedule word by word and replays it byte by byte,
// last round key first, for the decryption datapath.
module round_key_memory #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_changed,
    input  logic        wr_en,
    input  logic [31:0] store_key_memory,
    input  logic        rd_start,
    input  logic        rd_en,
    output logic [7:0]  key_from_memory,
    output logic        key_byte_valid,
    output logic        key_ready,
    output logic        round_done,
    output logic        all_done,
    output logic        seq_err
);

    localparam int DEPTH = 4 * (NUM_ROUNDS + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = $clog2(NUM_ROUNDS + 1);

    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] READY = 2'd1;
    localparam logic [1:0] READ  = 2'd2;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [RW-1:0] TOP_ROUND = RW'(NUM_ROUNDS);

    logic [1:0]    state;
    logic [AW-1:0] wr_ptr;
    logic [RW-1:0] round_cnt;
    logic [3:0]    byte_cnt;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic          do_write;
    logic          bad_req;

    assign do_write  = (state == FILL) && wr_en && !key_changed;
    assign bad_req   = !key_changed &&
                       ((wr_en && (state != FILL)) || (rd_start && (state == FILL)));
    assign key_ready = (state != FILL);

    // Word index 4*round_cnt + byte_cnt/4 is simply the concatenation of the two counters.
    assign rd_addr = AW'({round_cnt, byte_cnt[3:2]});
    assign rd_word = mem[rd_addr];

    always_comb begin
        rd_byte = 8'h00;
        case (byte_cnt[1:0])
            2'd0:    rd_byte = rd_word[31:24];
            2'd1:    rd_byte = rd_word[23:16];
            2'd2:    rd_byte = rd_word[15:8];
            default: rd_byte = rd_word[7:0];
        endcase
    end

    // Storage has no reset: validity is carried only by the FSM state.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= store_key_memory;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= FILL;
            wr_ptr          <= '0;
            round_cnt       <= '0;
            byte_cnt        <= '0;
            key_from_memory <= '0;
            key_byte_valid  <= 1'b0;
            round_done      <= 1'b0;
            all_done        <= 1'b0;
            seq_err         <= 1'b0;
        end else begin
            key_byte_valid <= 1'b0;
            round_done     <= 1'b0;
            all_done       <= 1'b0;
            seq_err        <= bad_req;
            if (key_changed) begin
                state  <= FILL;
                wr_ptr <= '0;
            end else begin
                case (state)
                    FILL: begin
                        if (wr_en) begin
                            if (wr_ptr == LAST_ADDR) begin
                                state  <= READY;
                                wr_ptr <= '0;
                            end else begin
                                wr_ptr <= wr_ptr + 1'b1;
                            end
                        end
                    end
                    READY: begin
                        if (rd_start) begin
                            state     <= READ;
                            round_cnt <= TOP_ROUND;
                            byte_cnt  <= '0;
                        end
                    end
                    READ: begin
                        if (rd_start) begin
                            round_cnt <= TOP_ROUND;
                            byte_cnt  <= '0;
                        end else if (rd_en) begin
                            key_from_memory <= rd_byte;
                            key_byte_valid  <= 1'b1;
                            byte_cnt        <= byte_cnt + 4'd1;
                            if (byte_cnt == 4'd15) begin
                                round_done <= 1'b1;
                                if (round_cnt == '0) begin
                                    all_done <= 1'b1;
                                    state    <= READY;
                                end else begin
                                    round_cnt <= round_cnt - 1'b1;
                                end
                            end
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule
